// File: rtl/exc_pkg.sv
// Shared definitions for the precise-exception pipeline: code width, MIPS ExcCode values
// and the default PCs used on reset and on exception entry.
package exc_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_FLUSH_PC = 32'h0000_4180;

endpackage

// File: rtl/exc_pipe_stage.sv
// One pipeline boundary register for PC, BD flag, valid bit and the first exception code.
// Priority: reset > flush > stall (!en) > bubble > normal load.
module exc_pipe_stage #(
  parameter int              PC_W     = 32,
  parameter int              EXC_W    = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] FLUSH_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             en,
  input  logic             bubble,
  input  logic [PC_W-1:0]  src_pc,
  input  logic             src_bd,
  input  logic             src_valid,
  input  logic             src_exc_vld,
  input  logic [EXC_W-1:0] src_exc_code,
  input  logic             inj_vld,
  input  logic [EXC_W-1:0] inj_code,
  output logic [PC_W-1:0]  pc,
  output logic             bd,
  output logic             valid,
  output logic             exc_vld,
  output logic [EXC_W-1:0] exc_code
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      bd       <= 1'b0;
      valid    <= 1'b0;
      exc_vld  <= 1'b0;
      exc_code <= '0;
    end else if (flush) begin
      pc       <= FLUSH_PC;
      bd       <= 1'b0;
      valid    <= 1'b0;
      exc_vld  <= 1'b0;
      exc_code <= '0;
    end else if (en) begin
      // PC/BD always follow the source so an interrupt taken on a bubble reports the right EPC.
      pc <= src_pc;
      bd <= src_bd;
      if (bubble) begin
        valid   <= 1'b0;
        exc_vld <= 1'b0;
      end else begin
        valid    <= src_valid;
        exc_vld  <= src_exc_vld | (inj_vld & src_valid);
        exc_code <= src_exc_vld ? src_exc_code : (inj_vld ? inj_code : '0);
      end
    end
  end

endmodule

// File: rtl/exc_info_pipe.sv
// Chain of exc_pipe_stage registers carrying precise-exception state from decode to writeback.
// Stage 0 takes the pipeline inputs; stage i>0 takes the registered outputs of stage i-1.
module exc_info_pipe #(
  parameter int              NUM_STAGES = 3,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = exc_pkg::EXC_W,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(exc_pkg::DEF_RESET_PC),
  parameter logic [PC_W-1:0] FLUSH_PC   = PC_W'(exc_pkg::DEF_FLUSH_PC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_STAGES-1:0]       en,
  input  logic [NUM_STAGES-1:0]       bubble,
  input  logic [PC_W-1:0]             pc_in,
  input  logic                        bd_in,
  input  logic                        valid_in,
  input  logic [NUM_STAGES-1:0]       inj_vld,
  input  logic [NUM_STAGES*EXC_W-1:0] inj_code,
  output logic [NUM_STAGES*PC_W-1:0]  pc_out,
  output logic [NUM_STAGES-1:0]       bd_out,
  output logic [NUM_STAGES-1:0]       valid_out,
  output logic [NUM_STAGES-1:0]       exc_vld,
  output logic [NUM_STAGES*EXC_W-1:0] exc_code
);

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic [PC_W-1:0]  s_pc;
    logic             s_bd;
    logic             s_valid;
    logic             s_exc_vld;
    logic [EXC_W-1:0] s_exc_code;

    if (i == 0) begin : g_src_in
      // New instructions enter with no exception; detection happens via inj_vld[0].
      assign s_pc       = pc_in;
      assign s_bd       = bd_in;
      assign s_valid    = valid_in;
      assign s_exc_vld  = 1'b0;
      assign s_exc_code = '0;
    end else begin : g_src_prev
      assign s_pc       = pc_out[(i-1)*PC_W +: PC_W];
      assign s_bd       = bd_out[i-1];
      assign s_valid    = valid_out[i-1];
      assign s_exc_vld  = exc_vld[i-1];
      assign s_exc_code = exc_code[(i-1)*EXC_W +: EXC_W];
    end

    exc_pipe_stage #(
      .PC_W     (PC_W),
      .EXC_W    (EXC_W),
      .RESET_PC (RESET_PC),
      .FLUSH_PC (FLUSH_PC)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .en           (en[i]),
      .bubble       (bubble[i]),
      .src_pc       (s_pc),
      .src_bd       (s_bd),
      .src_valid    (s_valid),
      .src_exc_vld  (s_exc_vld),
      .src_exc_code (s_exc_code),
      .inj_vld      (inj_vld[i]),
      .inj_code     (inj_code[i*EXC_W +: EXC_W]),
      .pc           (pc_out[i*PC_W +: PC_W]),
      .bd           (bd_out[i]),
      .valid        (valid_out[i]),
      .exc_vld      (exc_vld[i]),
      .exc_code     (exc_code[i*EXC_W +: EXC_W])
    );
  end

endmodule
